// File: rtl/core_exec_div_if.sv
// core_exec_div_if: request/response bundle between the execute stage and the
// iterative divider.
`default_nettype none

interface core_exec_div_if;
  logic        start;
  logic [1:0]  div_op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] div_result;

  modport master (
    output start, div_op, opa, opb, flush,
    input  busy, done, div_result
  );

  modport slave (
    input  start, div_op, opa, opb, flush,
    output busy, done, div_result
  );
endinterface

`default_nettype wire

// File: rtl/core_exec_div.sv
// -----------------------------------------------------------------------------
// core_exec_div : 32-step restoring radix-2 divider for DIV/DIVU/REM/REMU
// Revision      : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module core_exec_div (
  input  wire             clk,
  input  wire             rst,
  core_exec_div_if.slave  div_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic [5:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_rem_sel;

  logic        w_signed;
  logic        w_accept;
  logic        w_div0;
  logic        w_ovf;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [33:0] w_trial;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quot_nx;
  logic [31:0] w_final;

  assign w_signed = ~div_if.div_op[0];
  assign w_accept = div_if.start & ~div_if.flush;
  assign w_div0   = (div_if.opb == 32'd0);
  assign w_ovf    = w_signed & (div_if.opa == 32'h8000_0000) & (div_if.opb == 32'hFFFF_FFFF);
  assign w_abs_a  = (w_signed & div_if.opa[31]) ? (32'd0 - div_if.opa) : div_if.opa;
  assign w_abs_b  = (w_signed & div_if.opb[31]) ? (32'd0 - div_if.opb) : div_if.opb;

  // Extra top bit makes the borrow of the 33-bit trial subtraction visible.
  assign w_trial   = {1'b0, r_rem, r_dvd[31]} - {2'b00, r_dvs};
  assign w_rem_nx  = w_trial[33] ? {r_rem[30:0], r_dvd[31]} : w_trial[31:0];
  assign w_quot_nx = {r_quot[30:0], ~w_trial[33]};
  assign w_final   = r_rem_sel ? (r_neg_r ? (32'd0 - w_rem_nx)  : w_rem_nx)
                               : (r_neg_q ? (32'd0 - w_quot_nx) : w_quot_nx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= 32'd0;
      r_rem     <= 32'd0;
      r_quot    <= 32'd0;
      r_dvd     <= 32'd0;
      r_dvs     <= 32'd0;
      r_cnt     <= 6'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem_sel <= div_if.div_op[1];
            r_busy    <= 1'b1;
            if (w_div0) begin
              r_result <= div_if.div_op[1] ? div_if.opa : 32'hFFFF_FFFF;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else if (w_ovf) begin
              r_result <= div_if.div_op[1] ? 32'd0 : 32'h8000_0000;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_rem   <= 32'd0;
              r_quot  <= 32'd0;
              r_dvd   <= w_abs_a;
              r_dvs   <= w_abs_b;
              r_neg_q <= w_signed & (div_if.opa[31] ^ div_if.opb[31]);
              r_neg_r <= w_signed & div_if.opa[31];
              r_cnt   <= 6'd0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (div_if.flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_rem  <= w_rem_nx;
            r_quot <= w_quot_nx;
            r_dvd  <= {r_dvd[30:0], 1'b0};
            r_cnt  <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) begin
              r_result <= w_final;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Completion cycle is already visible; flush here has nothing to cancel.
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign div_if.busy       = r_busy;
  assign div_if.done       = r_done;
  assign div_if.div_result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_core_exec_div.sv
// tb_core_exec_div: directed checks of core_exec_div results, latency, flush,
// ignored start and asynchronous reset.
`default_nettype none

module tb_core_exec_div;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   done_cnt;

  core_exec_div_if div_if ();

  core_exec_div u_dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (div_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (div_if.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge one cycle after done.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int n;
    div_if.start  = 1'b1;
    div_if.div_op = op;
    div_if.opa    = a;
    div_if.opb    = b;
    @(posedge clk);
    #1 div_if.start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (div_if.done !== 1'b1 && n < 40);
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " result"}, div_if.div_result, exp_res);
    check({tag, " busy at done"}, {31'd0, div_if.busy}, 32'd1);
    @(negedge clk);
    check({tag, " busy after"}, {31'd0, div_if.busy}, 32'd0);
  endtask

  initial begin
    int dc0;
    int n;
    n_checks      = 0;
    n_fail        = 0;
    done_cnt      = 0;
    rst           = 1'b1;
    div_if.start  = 1'b0;
    div_if.flush  = 1'b0;
    div_if.div_op = 2'b00;
    div_if.opa    = 32'd0;
    div_if.opb    = 32'd0;

    @(negedge clk);
    check("reset busy", {31'd0, div_if.busy}, 32'd0);
    check("reset done", {31'd0, div_if.done}, 32'd0);
    check("reset result", div_if.div_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("DIV -7/2",      OP_DIV,  32'hFFFF_FFF9, 32'd2,          33, 32'hFFFF_FFFD);
    run_op("REM -7/2",      OP_REM,  32'hFFFF_FFF9, 32'd2,          33, 32'hFFFF_FFFF);
    run_op("DIVU 100/7",    OP_DIVU, 32'd100,       32'd7,          33, 32'd14);
    run_op("REMU 100/7",    OP_REMU, 32'd100,       32'd7,          33, 32'd2);
    run_op("DIVU max/1",    OP_DIVU, 32'hFFFF_FFFF, 32'd1,          33, 32'hFFFF_FFFF);
    run_op("DIV 7/-2",      OP_DIV,  32'd7,         32'hFFFF_FFFE,  33, 32'hFFFF_FFFD);
    run_op("REM 7/-2",      OP_REM,  32'd7,         32'hFFFF_FFFE,  33, 32'd1);
    run_op("DIV 5/0",       OP_DIV,  32'd5,         32'd0,          1,  32'hFFFF_FFFF);
    run_op("REMU 1234/0",   OP_REMU, 32'h1234,      32'd0,          1,  32'h1234);
    run_op("DIV ovf",       OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  1,  32'h8000_0000);
    run_op("REM ovf",       OP_REM,  32'h8000_0000, 32'hFFFF_FFFF,  1,  32'd0);
    run_op("DIVU 0x80000000/max", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);

    // Flush in T+10; prior result is 0 from the previous op, so seed a non-zero one.
    run_op("REMU 1234/0 b", OP_REMU, 32'h1234, 32'd0, 1, 32'h1234);
    div_if.start  = 1'b1;
    div_if.div_op = OP_DIVU;
    div_if.opa    = 32'd1000;
    div_if.opb    = 32'd3;
    @(posedge clk);
    #1 div_if.start = 1'b0;
    dc0 = done_cnt;
    repeat (10) @(negedge clk);
    div_if.flush = 1'b1;
    @(posedge clk);
    #1 div_if.flush = 1'b0;
    @(negedge clk);
    check("flush busy", {31'd0, div_if.busy}, 32'd0);
    check("flush done", {31'd0, div_if.done}, 32'd0);
    check("flush keeps result", div_if.div_result, 32'h1234);
    run_op("DIVU after flush", OP_DIVU, 32'd1000, 32'd3, 33, 32'd333);
    check("flush no extra done", 32'(done_cnt - dc0), 32'd1);

    // flush together with start in IDLE blocks acceptance
    div_if.start  = 1'b1;
    div_if.flush  = 1'b1;
    div_if.div_op = OP_DIV;
    div_if.opa    = 32'd5;
    div_if.opb    = 32'd0;
    @(posedge clk);
    #1;
    div_if.start = 1'b0;
    div_if.flush = 1'b0;
    @(negedge clk);
    check("start+flush busy", {31'd0, div_if.busy}, 32'd0);
    check("start+flush done", {31'd0, div_if.done}, 32'd0);

    // start pulsed in T+5 while busy is ignored
    @(negedge clk);
    div_if.start  = 1'b1;
    div_if.div_op = OP_DIVU;
    div_if.opa    = 32'd100;
    div_if.opb    = 32'd7;
    @(posedge clk);
    #1 div_if.start = 1'b0;
    dc0 = done_cnt;
    repeat (5) @(negedge clk);
    div_if.start = 1'b1;
    div_if.opa   = 32'd50;
    div_if.opb   = 32'd0;
    @(posedge clk);
    #1 div_if.start = 1'b0;
    n = 5;
    do begin
      @(negedge clk);
      n++;
    end while (div_if.done !== 1'b1 && n < 40);
    check("busy start latency", 32'(n), 32'd33);
    check("busy start result", div_if.div_result, 32'd14);
    repeat (3) @(negedge clk);
    #2 check("busy start one done", 32'(done_cnt - dc0), 32'd1);

    // asynchronous reset in T+20
    @(negedge clk);
    div_if.start  = 1'b1;
    div_if.div_op = OP_DIVU;
    div_if.opa    = 32'd1000;
    div_if.opb    = 32'd3;
    @(posedge clk);
    #1 div_if.start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre-reset busy", {31'd0, div_if.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid reset busy", {31'd0, div_if.busy}, 32'd0);
    check("mid reset done", {31'd0, div_if.done}, 32'd0);
    check("mid reset result", div_if.div_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dc0 = done_cnt;
    repeat (40) @(negedge clk);
    #2;
    check("reset no done", 32'(done_cnt - dc0), 32'd0);
    check("reset idle busy", {31'd0, div_if.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
